rangefinder_sample_capture: RTL



---
 rtl/rangefinder_capture_pkg.sv | 19 +
 rtl/rangefinder_sample_bank.sv | 19 +
 rtl/rangefinder_sample_capture.sv | 137 +++++++++++++
 3 files changed

// File: rtl/rangefinder_capture_pkg.sv
// rangefinder_capture_pkg: shared states, CSR offsets and bit positions for the sample capture block
package rangefinder_capture_pkg;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;
  localparam logic [1:0] CSR_CTRL     = 2'd0;
  localparam logic [1:0] CSR_STATUS   = 2'd1;
  localparam logic [1:0] CSR_PRETRIG  = 2'd2;
  localparam logic [1:0] CSR_TRIG_PTR = 2'd3;
  localparam int CTRL_ARM     = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int CTRL_SW_TRIG = 3;
  localparam int STATUS_DONE  = 3;
endpackage

// File: rtl/rangefinder_sample_bank.sv
// rangefinder_sample_bank: simple dual-port sample RAM, registered read returns old data on collision
module rangefinder_sample_bank #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]        rdata_o
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end
endmodule

// File: rtl/rangefinder_sample_capture.sv
// rangefinder_sample_capture: multi-channel pre-trigger capture buffers with Avalon-MM CSR and aligned readout
module rangefinder_sample_capture
  import rangefinder_capture_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 256,
  parameter int CHANNELS    = 2,
  parameter int PRETRIG_RST = 32,
  parameter int ADDR_W      = $clog2(CHANNELS*DEPTH)+1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_valid,
  input  logic [CHANNELS*DATA_W-1:0] sample_data,
  input  logic                       trigger_in,
  input  logic [ADDR_W-1:0]          address,
  input  logic                       chipselect,
  input  logic                       read,
  input  logic                       write,
  input  logic [31:0]                writedata,
  output logic [31:0]                readdata,
  output logic                       irq
);
  localparam int L   = $clog2(DEPTH);
  localparam int CHW = ADDR_W - L;
  state_t state_q;
  logic [L-1:0] wr_ptr_q, fill_q, trig_ptr_q, pretrig_q, rd_idx;
  logic [L:0] post_q, post_tgt;
  logic done_q, irq_en_q, pend_q;
  logic csr_wr, ctrl_wr, arm, abort, sw_trig, trig_any, fire, post_end, we;
  logic [1:0] off;
  logic [ADDR_W-2:0] w;
  logic [CHW-1:0] ch, ch_q;
  logic rd_req, smp_sel, smp_q;
  logic [31:0] csr_val, csr_q;
  logic [DATA_W-1:0] bank_q [CHANNELS];
  logic [DATA_W-1:0] smp;
  logic unused_wd;
  assign unused_wd = ^writedata[31:4];
  assign off      = address[1:0];
  assign csr_wr   = chipselect & write & ~address[ADDR_W-1];
  assign ctrl_wr  = csr_wr & (off == CSR_CTRL);
  assign abort    = ctrl_wr & writedata[CTRL_ABORT];
  assign arm      = ctrl_wr & writedata[CTRL_ARM] & ~writedata[CTRL_ABORT];
  assign sw_trig  = ctrl_wr & writedata[CTRL_SW_TRIG];
  assign trig_any = trigger_in | sw_trig | pend_q;
  assign fire     = (state_q == ST_ARMED) & trig_any & sample_valid;
  assign post_tgt = (L+1)'(DEPTH) - {1'b0, pretrig_q};
  assign post_end = post_q == post_tgt;
  assign we = sample_valid & ~arm & ~abort &
              (state_q == ST_PRE || state_q == ST_ARMED || (state_q == ST_POST && !post_end));
  assign irq = done_q & irq_en_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      post_q     <= '0;
      trig_ptr_q <= '0;
      done_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      pend_q     <= 1'b0;
      pretrig_q  <= L'(PRETRIG_RST);
    end else begin
      if (ctrl_wr) irq_en_q <= writedata[CTRL_IRQ_EN];
      if (csr_wr && off == CSR_STATUS && writedata[STATUS_DONE]) done_q <= 1'b0;
      if (csr_wr && off == CSR_PRETRIG && (state_q == ST_IDLE || state_q == ST_DONE))
        pretrig_q <= writedata[L-1:0];
      if (we) wr_ptr_q <= wr_ptr_q + L'(1);
      if (abort) begin
        state_q <= ST_IDLE;
        pend_q  <= 1'b0;
      end else if (arm) begin
        state_q <= ST_PRE;
        done_q  <= 1'b0;
        fill_q  <= '0;
        post_q  <= '0;
        pend_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_PRE:
            if (fill_q == pretrig_q) state_q <= ST_ARMED;
            else if (sample_valid) fill_q <= fill_q + L'(1);
          ST_ARMED:
            if (fire) begin
              trig_ptr_q <= wr_ptr_q;
              post_q     <= (L+1)'(1);
              pend_q     <= 1'b0;
              state_q    <= ST_POST;
            end else pend_q <= trig_any;
          ST_POST:
            if (post_end) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else if (sample_valid) post_q <= post_q + (L+1)'(1);
          default: ;
        endcase
      end
    end
  end
  // Readout is rotated so index PRETRIG lands on the trigger sample
  assign w       = address[ADDR_W-2:0];
  assign ch      = CHW'(w >> L);
  assign rd_idx  = trig_ptr_q - pretrig_q + w[L-1:0];
  assign rd_req  = chipselect & read;
  assign smp_sel = address[ADDR_W-1];
  assign csr_val = off == CSR_CTRL   ? 32'(irq_en_q) << CTRL_IRQ_EN :
                   off == CSR_STATUS ? 32'({done_q, state_q}) :
                   off == CSR_PRETRIG ? 32'(pretrig_q) : 32'(trig_ptr_q);
  always_ff @(posedge clk) begin
    if (reset) begin
      smp_q <= 1'b0;
      ch_q  <= '0;
      csr_q <= '0;
    end else if (rd_req) begin
      smp_q <= smp_sel;
      ch_q  <= ch;
      csr_q <= smp_sel ? '0 : csr_val;
    end
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_bank
    rangefinder_sample_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_bank (
      .clk     (clk),
      .we_i    (we),
      .waddr_i (wr_ptr_q),
      .wdata_i (sample_data[c*DATA_W +: DATA_W]),
      .re_i    (rd_req & smp_sel),
      .raddr_i (rd_idx),
      .rdata_o (bank_q[c])
    );
  end
  always_comb begin
    smp = '0;
    for (int c = 0; c < CHANNELS; c++) if (ch_q == CHW'(c)) smp = bank_q[c];
  end
  assign readdata = smp_q ? 32'(smp) : csr_q;
endmodule
